sqrt_seq_ctrl: RTL and testbench

//  Sequential integer square root: one root bit per clock, restoring digit-by-digit method.

---
 rtl/sqrt_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_sqrt_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : sqrt_seq_ctrl
// Description : Sequential integer square root using the restoring
//               digit-by-digit method, one root bit per clock. Accepts a
//               WIDTH-bit radicand on start and returns floor(sqrt(x)) plus
//               the remainder x - root^2 with a one-cycle done pulse.
//               Optional macro SQRT_ROUND_EN rounds the root output to nearest
//               (saturating); rem always stays unrounded.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sqrt_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     radicand,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     rem
);

    localparam int N     = WIDTH / 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    logic [1:0]        state_q,     state_d;
    logic [WIDTH-1:0]  work_x_q,    work_x_d;
    logic [N+1:0]      work_rem_q,  work_rem_d;
    logic [N-1:0]      work_root_q, work_root_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [N-1:0]      root_q,      root_d;
    logic [N:0]        rem_q,       rem_d;

    logic [1:0]        w_pair;
    logic [N+4:0]      w_trial;
    logic              w_neg;
    logic [N+1:0]      w_rem_next;
    logic [N-1:0]      w_root_next;
    logic [N-1:0]      w_root_out;
    logic              w_unused_bits;

    // One restoring iteration: try subtracting (4*root + 1) from the shifted remainder
    always_comb begin
        w_pair      = work_x_q[WIDTH-1 -: 2];
        w_trial     = {1'b0, work_rem_q, w_pair} - {3'b000, work_root_q, 2'b01};
        w_neg       = w_trial[N+4];
        // Partial remainder never exceeds 2*root, so the upper bits dropped here are zero
        w_rem_next  = w_neg ? {work_rem_q[N-1:0], w_pair} : w_trial[N+1:0];
        w_root_next = {work_root_q[N-2:0], ~w_neg};
    end

`ifdef SQRT_ROUND_EN
    logic w_round_up;

    // Round to nearest: floor_rem > floor_root means x is past (root+0.5)^2; saturate at all-ones
    always_comb begin
        w_round_up = (w_rem_next[N:0] > {1'b0, w_root_next}) && (w_root_next != '1);
        w_root_out = w_root_next + N'(w_round_up);
    end
`else
    // Floor result passes straight through
    always_comb begin
        w_root_out = w_root_next;
    end
`endif

    assign w_unused_bits = ^{w_trial[N+3:N+2], work_rem_q[N+1:N], w_rem_next[N+1]};

    // Control FSM and datapath next-state
    always_comb begin
        state_d     = state_q;
        work_x_d    = work_x_q;
        work_rem_d  = work_rem_q;
        work_root_d = work_root_q;
        cnt_d       = cnt_q;
        root_d      = root_q;
        rem_d       = rem_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start) begin
                    work_x_d    = radicand;
                    work_rem_d  = '0;
                    work_root_d = '0;
                    cnt_d       = '0;
                    state_d     = c_CALC;
                end else begin
                    state_d     = c_IDLE;
                end
            end
            c_CALC: begin
                work_x_d    = {work_x_q[WIDTH-3:0], 2'b00};
                work_rem_d  = w_rem_next;
                work_root_d = w_root_next;
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    root_d  = w_root_out;
                    rem_d   = w_rem_next[N:0];
                    state_d = c_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            work_x_q    <= '0;
            work_rem_q  <= '0;
            work_root_q <= '0;
            cnt_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            work_x_q    <= work_x_d;
            work_rem_q  <= work_rem_d;
            work_root_q <= work_root_d;
            cnt_q       <= cnt_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
        end
    end

    assign busy = (state_q == c_CALC);
    assign done = (state_q == c_DONE);
    assign root = root_q;
    assign rem  = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_sqrt_seq_ctrl
// Description : Self-checking bench for sqrt_seq_ctrl (WIDTH=16). Directed
//               operands with hand-computed results, busy/back-to-back and
//               reset-abort scenarios, plus a short random sweep.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sqrt_seq_ctrl;

    localparam int W = 16;
    localparam int N = W / 2;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   radicand;
    logic           busy;
    logic           done;
    logic [N-1:0]   root;
    logic [N:0]     rem;

    int n_checks;
    int n_errors;

    sqrt_seq_ctrl #(.WIDTH(W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .radicand (radicand),
        .busy     (busy),
        .done     (done),
        .root     (root),
        .rem      (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int isqrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int exp_root(input int x);
        int r;
        r = isqrt(x);
`ifdef SQRT_ROUND_EN
        if ((x - r * r) > r && r < (1 << N) - 1) r++;
`endif
        return r;
    endfunction

    // Called at posedge+1 after the accepting edge; returns edges until done (0 on timeout)
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= N + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
        check("done_busy_excl", {31'd0, done & busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input int x, input int r_exp, input int m_exp);
        int lat;
        int bc;
        start = 1'b1;
        radicand = W'(x);
        @(posedge clk); #1;
        start = 1'b0;
        radicand = W'($urandom);
        wait_done(lat, bc);
        check({tag, "_lat"},  lat,  N);
        check({tag, "_root"}, {24'd0, root}, r_exp);
        check({tag, "_rem"},  {23'd0, rem},  m_exp);
    endtask

    initial begin
        int lat;
        int bc;
        int x;
        logic seen;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        radicand = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_root", {24'd0, root}, 0);
        check("rst_rem",  {23'd0, rem},  0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 144: latency and busy duration
        start = 1'b1;
        radicand = 16'd144;
        @(posedge clk); #1;
        start = 1'b0;
        check("t1_busy_e0", {31'd0, busy}, 1);
        wait_done(lat, bc);
        check("t1_lat",   lat, N);
        check("t1_busycyc", bc, N);
        check("t1_root", {24'd0, root}, 12);
        check("t1_rem",  {23'd0, rem},  0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_hold_root", {24'd0, root}, 12);
        check("t1_hold_done", {31'd0, done}, 0);

`ifdef SQRT_ROUND_EN
        run_op("r157", 157, 13, 13);
        run_op("r65535", 65535, 255, 510);
`else
        run_op("r157", 157, 12, 13);
        run_op("r65535", 65535, 255, 510);
`endif
        run_op("r156", 156, 12, 12);
        run_op("r0", 0, 0, 0);
        run_op("r1", 1, 1, 0);
        run_op("r3", 3, exp_root(3), 2);

        // start held, radicand changed mid-CALC, then back-to-back accept
        @(posedge clk); #1;
        start = 1'b1;
        radicand = 16'd150;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        radicand = 16'd9999;
        wait_done(lat, bc);
        check("t4_lat", lat, N - 3);
        check("t4_root", {24'd0, root}, exp_root(150));
        check("t4_rem",  {23'd0, rem},  6);
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_b2b_busy", {31'd0, busy}, 1);
        check("t4_b2b_done", {31'd0, done}, 0);
        wait_done(lat, bc);
        check("t4b_lat", lat, N);
`ifdef SQRT_ROUND_EN
        check("t4b_root", {24'd0, root}, 100);
`else
        check("t4b_root", {24'd0, root}, 99);
`endif
        check("t4b_rem", {23'd0, rem}, 198);

        // reset mid-operation aborts with no done
        @(posedge clk); #1;
        start = 1'b1;
        radicand = 16'd1000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t5_busy", {31'd0, busy}, 0);
        check("t5_done", {31'd0, done}, 0);
        check("t5_root", {24'd0, root}, 0);
        check("t5_rem",  {23'd0, rem},  0);
        seen = 1'b0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            seen = seen | done | busy;
        end
        check("t5_no_done", {31'd0, seen}, 0);
        start = 1'b1;
        rst_n = 1'b0;
        radicand = 16'd500;
        @(posedge clk); #1;
        check("t5_rst_start_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("t5_idle_busy", {31'd0, busy}, 0);
        check("t5_idle_done", {31'd0, done}, 0);

        // random sweep against the model
        for (int i = 0; i < 300; i++) begin
            x = int'($urandom_range(0, 65535));
            run_op("rand", x, exp_root(x), x - isqrt(x) * isqrt(x));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
